// File: rtl/pulse_train_rx_if.sv
// Producer-to-consumer handshake for pulse_train_rx: active-low data-valid,
// value bus, and registered ready-for-data back to the producer.
interface pulse_train_rx_if #(
    parameter int NUM_W = 2
) ();
    logic             dav_;
    logic [NUM_W-1:0] numero;
    logic             rfd;

    modport master (output dav_, output numero, input rfd);
    modport slave  (input dav_, input numero, output rfd);
endinterface

// File: rtl/pulse_train_rx.sv
// Pulse-length consumer: each accepted value v yields (v+1)*SCALE high cycles on out,
// then GAP_CYC low cycles. Define PULSE_TRAIN_PREFETCH_EN to accept the next value mid-pulse.
module pulse_train_rx #(
    parameter int NUM_W   = 2,
    parameter int SCALE   = 2,
    parameter int GAP_CYC = 1
) (
    input  logic              clock,
    input  logic              reset,
    pulse_train_rx_if.slave   bus,
    output logic              out
);
    localparam int CNT_W = $clog2((2**NUM_W) * SCALE + 1);
    localparam int GAP_W = (GAP_CYC > 0) ? $clog2(GAP_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] SCALE_C  = CNT_W'(SCALE);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : {GAP_W{1'b0}};

    typedef enum logic [1:0] {IN_IDLE = 2'd0, IN_ACK = 2'd1, IN_HOLD = 2'd2} in_state_t;
    typedef enum logic [1:0] {IDLE = 2'd0, PULSE = 2'd1, GAP = 2'd2} pl_state_t;

    in_state_t        in_state_r, in_state_s;
    pl_state_t        pl_state_r, pl_state_s;
    logic [NUM_W-1:0] buf_r, buf_s;
    logic             valid_r, valid_s;
    logic [CNT_W-1:0] count_r, count_s;
    logic [GAP_W-1:0] gap_r, gap_s;
    logic             out_r, out_s;
    logic             rfd_r, rfd_s;
    logic             load_s, set_valid_s, enter_idle_s, release_s;
    logic [CNT_W-1:0] load_len_s;

    assign bus.rfd = rfd_r;
    assign out     = out_r;

    // Next-state and output logic for the pulse FSM and the input handshake FSM
    always_comb begin
        pl_state_s  = pl_state_r;
        in_state_s  = in_state_r;
        buf_s       = buf_r;
        count_s     = count_r;
        gap_s       = gap_r;
        out_s       = out_r;
        load_s      = 1'b0;
        set_valid_s = 1'b0;
        // Zero-extended before the add so (BUF+1)*SCALE cannot wrap.
        load_len_s  = ({{(CNT_W-NUM_W){1'b0}}, buf_r} + CNT_ONE) * SCALE_C;

        case (pl_state_r)
            IDLE: begin
                if (valid_r) begin
                    load_s = 1'b1;
                end else begin
                    pl_state_s = IDLE;
                end
            end
            PULSE: begin
                if (count_r == CNT_ONE) begin
                    if (GAP_CYC == 0) begin
                        if (valid_r) begin
                            load_s = 1'b1;
                        end else begin
                            out_s      = 1'b0;
                            pl_state_s = IDLE;
                        end
                    end else begin
                        out_s      = 1'b0;
                        gap_s      = GAP_LOAD;
                        pl_state_s = GAP;
                    end
                end else begin
                    count_s = count_r - CNT_ONE;
                end
            end
            GAP: begin
                if (gap_r == {GAP_W{1'b0}}) begin
                    if (valid_r) begin
                        load_s = 1'b1;
                    end else begin
                        pl_state_s = IDLE;
                    end
                end else begin
                    gap_s = gap_r - GAP_ONE;
                end
            end
            default: begin
                out_s      = 1'b0;
                pl_state_s = IDLE;
            end
        endcase

        if (load_s) begin
            count_s    = load_len_s;
            out_s      = 1'b1;
            pl_state_s = PULSE;
        end else begin
            count_s = count_s;
        end

        enter_idle_s = (pl_state_s == IDLE) && (pl_state_r != IDLE);
`ifdef PULSE_TRAIN_PREFETCH_EN
        release_s = load_s;
`else
        release_s = enter_idle_s;
`endif

        case (in_state_r)
            IN_IDLE: begin
                if (!bus.dav_) begin
                    buf_s      = bus.numero;
                    in_state_s = IN_ACK;
                end else begin
                    in_state_s = IN_IDLE;
                end
            end
            IN_ACK: begin
                if (bus.dav_) begin
                    set_valid_s = 1'b1;
                    in_state_s  = IN_HOLD;
                end else begin
                    in_state_s = IN_ACK;
                end
            end
            IN_HOLD: begin
                if (release_s) begin
                    in_state_s = IN_IDLE;
                end else begin
                    in_state_s = IN_HOLD;
                end
            end
            default: begin
                in_state_s = IN_IDLE;
            end
        endcase

        // Consuming the buffer wins over a concurrent set.
        if (load_s) begin
            valid_s = 1'b0;
        end else if (set_valid_s) begin
            valid_s = 1'b1;
        end else begin
            valid_s = valid_r;
        end

        rfd_s = (in_state_s == IN_IDLE);
    end

    // State and registered-output update
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            in_state_r <= IN_IDLE;
            pl_state_r <= IDLE;
            buf_r      <= {NUM_W{1'b0}};
            valid_r    <= 1'b0;
            count_r    <= {CNT_W{1'b0}};
            gap_r      <= {GAP_W{1'b0}};
            out_r      <= 1'b0;
            rfd_r      <= 1'b1;
        end else begin
            in_state_r <= in_state_s;
            pl_state_r <= pl_state_s;
            buf_r      <= buf_s;
            valid_r    <= valid_s;
            count_r    <= count_s;
            gap_r      <= gap_s;
            out_r      <= out_s;
            rfd_r      <= rfd_s;
        end
    end
endmodule

// File: tb/tb_pulse_train_rx.sv
// Directed bench for pulse_train_rx: default config on dut_a, NUM_W=4/SCALE=3 on dut_b.
module tb_pulse_train_rx;
    logic clock = 1'b0;
    logic reset = 1'b1;
    logic out_a, out_b;
    int   n_total = 0;
    int   n_bad   = 0;

    pulse_train_rx_if #(.NUM_W(2)) ifa ();
    pulse_train_rx_if #(.NUM_W(4)) ifb ();

    pulse_train_rx #(.NUM_W(2), .SCALE(2), .GAP_CYC(1)) dut_a (
        .clock(clock), .reset(reset), .bus(ifa), .out(out_a)
    );
    pulse_train_rx #(.NUM_W(4), .SCALE(3), .GAP_CYC(1)) dut_b (
        .clock(clock), .reset(reset), .bus(ifb), .out(out_b)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_total++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    function automatic logic get_rfd(input int sel);
        return (sel != 0) ? ifb.rfd : ifa.rfd;
    endfunction

    function automatic logic get_out(input int sel);
        return (sel != 0) ? out_b : out_a;
    endfunction

    task automatic drive(input int sel, input logic d, input int v);
        if (sel != 0) begin
            ifb.dav_ = d;
            ifb.numero = v[3:0];
        end else begin
            ifa.dav_ = d;
            ifa.numero = v[1:0];
        end
    endtask

    task automatic wait_rfd(input int sel);
        int n = 0;
        while (!get_rfd(sel) && n < 100) begin
            tick();
            n++;
        end
        check_eq("rfd_wait", int'(get_rfd(sel)), 1);
    endtask

    // Full handshake; returns at the sample right after the load edge.
    task automatic xfer(input int sel, input int v, input int hold);
        wait_rfd(sel);
        drive(sel, 1'b0, v);
        repeat (hold) begin
            tick();
            check_eq("rfd_low", int'(get_rfd(sel)), 0);
        end
        drive(sel, 1'b1, 0);
        tick();
        check_eq("out_preload", int'(get_out(sel)), 0);
        tick();
    endtask

    task automatic measure(input int sel, output int n);
        n = 0;
        while (get_out(sel) && n < 300) begin
            n++;
            tick();
        end
    endtask

    initial begin
        int len;
        int ps;
        int rise, h1, l1, h2, k;
        logic samp [24];
        logic rf   [24];

        ifa.dav_ = 1'b1; ifa.numero = 2'd0;
        ifb.dav_ = 1'b1; ifb.numero = 4'd0;
        repeat (3) tick();
        check_eq("rst_out_a", int'(out_a), 0);
        check_eq("rst_rfd_a", int'(ifa.rfd), 1);
        check_eq("rst_out_b", int'(out_b), 0);
        check_eq("rst_rfd_b", int'(ifb.rfd), 1);
        reset = 1'b0;
        tick();

        // value 3 -> 8 high cycles then a low gap
        xfer(0, 3, 1);
        check_eq("load_out", int'(out_a), 1);
        measure(0, len);
        check_eq("len_v3", len, 8);
`ifdef PULSE_TRAIN_PREFETCH_EN
        check_eq("rfd_at_fall", int'(ifa.rfd), 1);
`else
        check_eq("rfd_at_fall", int'(ifa.rfd), 0);
`endif
        tick();
        check_eq("gap_low", int'(out_a), 0);
        check_eq("rfd_after_gap", int'(ifa.rfd), 1);

        // value 0 -> SCALE cycles
        xfer(0, 0, 1);
        measure(0, len);
        check_eq("len_v0", len, 2);
        tick();

        // dav_ held low 5 cycles -> one capture, one 6-cycle pulse
        xfer(0, 2, 5);
        measure(0, len);
        check_eq("len_v2_hold", len, 6);
        repeat (4) tick();
        check_eq("no_second", int'(out_a), 0);

        // wide config, no wrap of the 6-bit count
        xfer(1, 15, 1);
        measure(1, len);
        check_eq("len_b_v15", len, 48);
        tick();

        // async reset in cycle 3 of an 8-cycle pulse
        xfer(0, 3, 1);
        tick();
        tick();
        check_eq("pre_reset_out", int'(out_a), 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_out", int'(out_a), 0);
        check_eq("async_rfd", int'(ifa.rfd), 1);
        @(posedge clock);
        #1 reset = 1'b0;
        xfer(0, 1, 1);
        measure(0, len);
        check_eq("len_after_rst", len, 4);
        tick();
        tick();

        // back-to-back values 1 then 2, producer reacts to rfd
        xfer(0, 1, 1);
        ps = 0;
        for (int i = 0; i < 24; i++) begin
            samp[i] = out_a;
            rf[i]   = ifa.rfd;
            if (ps == 0 && ifa.rfd) begin
                drive(0, 1'b0, 2);
                ps = 1;
            end else if (ps == 1) begin
                drive(0, 1'b1, 0);
                ps = 2;
            end else begin
                ps = ps;
            end
            tick();
        end
        rise = -1;
        for (int i = 23; i >= 0; i--) begin
            if (rf[i]) rise = i;
        end
        k = 0; h1 = 0; l1 = 0; h2 = 0;
        while (k < 24 && samp[k])  begin h1++; k++; end
        while (k < 24 && !samp[k]) begin l1++; k++; end
        while (k < 24 && samp[k])  begin h2++; k++; end
        check_eq("b2b_high1", h1, 4);
        check_eq("b2b_high2", h2, 6);
        check_eq("b2b_rfd_mid", int'(rf[4]), 0);
`ifdef PULSE_TRAIN_PREFETCH_EN
        check_eq("b2b_rfd_rise", rise, 0);
        check_eq("b2b_low", l1, 1);
        check_eq("b2b_load2", h1 + l1, 5);
`else
        check_eq("b2b_rfd_rise", rise, 5);
        check_eq("b2b_low", l1, 4);
        check_eq("b2b_load2", h1 + l1, 8);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/pulse_train_rx.md
# pulse_train_rx

Parametrised pulse-length consumer. It accepts an unsigned `NUM_W`-bit value from a producer over the `dav_`/`rfd` handshake. For each value it drives `out` high for exactly (value+1)·`SCALE` clock cycles, followed by a mandatory low gap of `GAP_CYC` cycles. It sits between a producer and timed-output logic. An optional one-entry prefetch buffer lets the next value be accepted while the current pulse runs.

## Interface
- `NUM_W`, default 2: width of `numero`; must be ≥1.
- `SCALE`, default 2: cycles per unit of (value+1); must be ≥1.
- `GAP_CYC`, default 1: forced `out`-low cycles after each pulse; must be ≥0.
- `CNT_W` (localparam): $clog2((2**NUM_W)·SCALE+1).

Ports:
- `clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high.
- `dav_`  in  1  producer data-valid, active low.
- `numero`  in  NUM_W  value; stable while `dav_`=0.
- `rfd`  out  1  ready-for-data, registered.
- `out`  out  1  pulse output, registered.

## Operation
- Reset (async, immediate, also mid-pulse): `out`=0, `rfd`=1, input FSM IN_IDLE, pulse FSM IDLE, buffer valid=0, COUNT=0.
- Input FSM:
  - IN_IDLE (`rfd`=1): when `dav_`=0 is sampled, capture `numero` into BUF, `rfd`←0, go IN_ACK.
  - IN_ACK (`rfd`=0): wait for `dav_`=1; then valid←1, go IN_HOLD.
  - IN_HOLD (`rfd`=0): return to IN_IDLE (`rfd`←1) when the release condition holds (see Configuration).
  - `dav_` held low for any number of cycles produces exactly one capture.
- Pulse FSM:
  - IDLE: if valid=1, then COUNT←(BUF+1)·SCALE, valid←0, `out`←1, go PULSE.
  - PULSE: COUNT←COUNT−1; when COUNT=1, `out`←0 and go GAP (go IDLE directly if GAP_CYC=0).
  - GAP: `out`=0; count GAP_CYC cycles, then go IDLE.
- Arithmetic: (BUF+1)·SCALE is computed at CNT_W bits and never overflows. The maximum is (2^NUM_W)·SCALE. Value 0 gives a pulse of SCALE cycles.
- `numero` is ignored outside the capture edge.

## Timing
- Edge A: `dav_`=0 sampled in IN_IDLE; `rfd` falls after A.
- Edge B: `dav_`=1 sampled in IN_ACK; valid set.
- Edge B+1 (the load edge, pulse FSM IDLE): `out` rises.
- `out` stays high exactly L=(value+1)·SCALE cycles and falls at load+L.
- Earliest next load is load+L+GAP_CYC. With GAP_CYC=0 and a ready value, `out` stays high continuously across pulses. This is legal.
- Simultaneous capture and consume: consume takes precedence for valid. A new capture is only possible from IN_IDLE, so the buffer is never overwritten.
- Reset deasserted mid-handshake: the producer sees `rfd`=1 and must restart the transfer.

## Configuration
- Macro `PULSE_TRAIN_PREFETCH_EN`.
- Defined: IN_HOLD releases on the edge that consumes valid, i.e. the load edge, so `rfd` rises together with `out`. The next value can complete its handshake during PULSE or GAP. The pulse FSM leaving GAP with valid=1 reloads directly, with no IDLE cycle, so the next pulse starts at exactly load+L+GAP_CYC.
- Undefined: IN_HOLD releases only when the pulse FSM enters IDLE, so `rfd` rises at load+L+GAP_CYC. The next load is no earlier than three edges later (capture, ack, load).

## Test plan
- NUM_W=2, SCALE=2, GAP_CYC=1, `numero`=3, `dav_` low 1 cycle → one pulse, `out` high exactly 8 cycles starting at edge B+1, then ≥1 low cycle.
- Same config, `numero`=0 → `out` high exactly 2 cycles. `numero`=2 with `dav_` held low 5 cycles → single capture, `rfd` low throughout, 6-cycle pulse.
- NUM_W=4, SCALE=3, `numero`=15 → `out` high exactly 48 cycles (COUNT width 6, no wrap).
- `reset` asserted at cycle 3 of an 8-cycle pulse → `out`=0 and `rfd`=1 immediately. The following transfer of value 1 gives a 4-cycle pulse.
- `PULSE_TRAIN_PREFETCH_EN` defined, values 1 then 2 sent back-to-back → `rfd` rises at the first load edge. The second value is accepted during the pulse. `out` is high 4, low exactly 1, high 6.
- Macro undefined, same stimulus → `rfd` stays 0 until 5 cycles after the first load. The second pulse starts 3 edges after `rfd` rises.
